alu_mul_sequencer: RTL

Multi-cycle controller that computes an unsigned 32x32 -> 64-bit product by sequencing the shared 32-bit RISC ALU through a shift-add algorithm. The block owns the ALU inputs (FS code, A, B) while busy and consumes its combinational result and carry-out. It sits beside the ALU in the RISC2 datapath. The core uses it for MUL instructions; the ALU itself has no multiplier.

---
 rtl/alu_mul_sequencer.sv | 62 ++++++
 1 files changed

// File: rtl/alu_mul_sequencer.sv
// alu_mul_sequencer: unsigned 32x32->64 shift-add multiplier that borrows the shared ALU for each add step.
module alu_mul_sequencer #(
    parameter logic [4:0] FS_ADD  = 5'b00010,
    parameter logic [4:0] FS_PASS = 5'b00000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] mult_a,
    input  logic [31:0] mult_b,
    input  logic [31:0] alu_out,
    input  logic        alu_cout,
    output logic [4:0]  fs,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic        busy,
    output logic        done,
    output logic [63:0] product
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_nx;
    logic [31:0] m, p_hi, p_lo;
    logic [5:0] cnt;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else state <= state_nx;
    end
    always_comb begin
        state_nx = state;
        fs = FS_PASS;
        alu_a = '0;
        alu_b = '0;
        busy = state != IDLE;
        done = state == DONE;
        if (state == IDLE) state_nx = start ? RUN : IDLE;
        else if (state == DONE) state_nx = IDLE;
        else begin
            state_nx = cnt == 6'd31 ? DONE : RUN;
            fs = FS_ADD;
            alu_a = p_hi;
            alu_b = p_lo[0] ? m : '0;
        end
    end
    // each RUN edge shifts {cout, sum, P_lo} right by one, retiring one multiplier bit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m <= '0;
            p_hi <= '0;
            p_lo <= '0;
            cnt <= '0;
        end else if (state == IDLE && start) begin
            m <= mult_a;
            p_hi <= '0;
            p_lo <= mult_b;
            cnt <= '0;
        end else if (state == RUN) begin
            {p_hi, p_lo} <= {alu_cout, alu_out, p_lo[31:1]};
            cnt <= cnt + 6'd1;
        end
    end
    assign product = {p_hi, p_lo};
endmodule
